cam_capture_writer: RTL and testbench
=====================================

// Module: cam_capture_writer
// PURPOSE
//  Write side of the camera->display pixel path: samples an 8-bit DVP camera bus (OV7670-style, RGB565,
//  two bytes/pixel, high byte first), packs each byte pair into one 16-bit pixel and pushes it into the
//  asynchronous pixel FIFO that the VGA display block reads. Aligns to frame start, crops to the
//  640x480 active window, and reports overflow, framing and line-length errors.
// PARAMETERS
//  H_ACTIVE    640  pixels written per line; extra pixels in a line are discarded
//  V_ACTIVE    480  lines written per frame; extra lines are discarded
//  SYNC_STAGES 2    flip-flop stages on cam_pclk/cam_vsync/cam_href/cam_data (>=2)
// PORTS
//  clk          in   1   system clock; must be >= 3x cam_pclk frequency
//  rst          in   1   synchronous, active-high reset
//  cam_pclk     in   1   camera pixel clock, sampled as data (asynchronous)
//  cam_vsync    in   1   high = vertical blanking
//  cam_href     in   1   high = active line bytes valid
//  cam_data     in   8   camera byte bus
//  full_fifo    in   1   FIFO write-side full
//  wr_en        out  1   one-cycle FIFO write strobe
//  dout         out  16  pixel {R[4:0],G[5:0],B[4:0]}; valid when wr_en=1
//  frame_start  out  1   one-cycle pulse: accepted frame begins (vsync falling edge)
//  frame_done   out  1   one-cycle pulse: V_ACTIVE lines of H_ACTIVE pixels delivered
//  overflow     out  1   sticky: a pixel was dropped because full_fifo=1
//  frame_err    out  1   sticky: vsync rose mid-frame, odd byte count at line end, or short line
//  pix_x        out  10  x of next pixel to write (0..H_ACTIVE-1)
//  pix_y        out  9   y of current line (0..V_ACTIVE-1)
// BEHAVIOUR
//  - Reset: all outputs 0, dout=16'h0000, state=WAIT_VS_HIGH, byte-phase=HI, counters 0; synchronizers
//    cleared. Reset mid-frame drops any half pixel; capture resumes only at the next full frame.
//  - Inputs pass through SYNC_STAGES flops, all four buses aligned; edges detected on the synced copies.
//    Byte captured on cam_pclk rising edge (synced) while synced href=1.
//  - FSM: WAIT_VS_HIGH --vsync=1--> WAIT_VS_LOW --vsync fall--> FRAME (pulse frame_start, x=y=0).
//    FRAME: href rise -> LINE (phase=HI). LINE: byte @ phase HI -> hold hi byte, phase=LO;
//    byte @ phase LO -> pixel complete, phase=HI. href fall -> FRAME, y+1, x=0.
//    When y reaches V_ACTIVE: pulse frame_done, go WAIT_VS_HIGH.
//  - Pixel complete with x<H_ACTIVE and y<V_ACTIVE: if !full_fifo, wr_en=1 for exactly one clk,
//    dout={hi,lo}, cycle after the lo-byte pclk edge is detected; if full_fifo, no write, overflow<=1.
//    x increments in both cases (position preserved; display stays geometrically aligned).
//  - x saturates at H_ACTIVE: further pixels in that line are dropped silently (no error).
//  - href fall with phase=LO: half pixel discarded, frame_err<=1. href fall with x<H_ACTIVE: frame_err<=1.
//  - vsync rise while in FRAME/LINE (y<V_ACTIVE): abort frame, frame_err<=1, no frame_done, go WAIT_VS_LOW.
//  - href rise and pclk edge in same clk: href takes effect first (byte counted as first of line).
//  - overflow/frame_err clear only on rst. Widths: x 10 bits, y 9 bits, no wrap beyond limits.
// STRUCTURE
//  - cam_pkg: state encoding localparams (WAIT_VS_HIGH, WAIT_VS_LOW, FRAME, LINE), RGB565 field
//    ranges, default H_ACTIVE/V_ACTIVE shared with the VGA side.
//  - One sub-module: cam_sync_edge (parameterised N-stage synchronizer + rise/fall pulse outputs),
//    instantiated for pclk, vsync, href; cam_data uses the same stage count without edge logic.
// TESTING
//  - Reset, then frame of 640x480 pixels, byte pairs 8'hF8,8'h1F -> 307200 wr_en pulses, dout=16'hF81F,
//    one frame_start, one frame_done, overflow=0, frame_err=0.
//  - Start stimulus mid-frame (vsync low) -> no writes until vsync high then low; first dout = pixel (0,0).
//  - full_fifo held 1 for pixels 10..19 of line 3 -> 10 missing writes, overflow=1, pixel 20 written at x=20.
//  - Line of 642 pixels -> 640 writes, no frame_err; line of 639.5 pixels (odd bytes) -> frame_err=1.
//  - vsync rises after line 100 -> no frame_done, frame_err=1, next frame captured normally from (0,0).
//  - rst asserted after hi byte of a pixel -> outputs 0 next clk, no write of the split pixel.

Source files
------------

// File: rtl/cam_capture_writer_pkg.sv
// Shared definitions for the camera capture write path: FSM states, byte
// phase, RGB565 field layout and the default active window shared with VGA.
package cam_capture_writer_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int X_W          = 10;
    localparam int Y_W          = 9;
    localparam int PIX_W        = 16;

    // RGB565 field ranges inside a packed pixel
    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        WAIT_VS_HIGH = 2'd0,
        WAIT_VS_LOW  = 2'd1,
        FRAME        = 2'd2,
        LINE         = 2'd3
    } cam_state_e;

    typedef enum logic {
        PH_HI = 1'b0,
        PH_LO = 1'b1
    } byte_phase_e;

    // The camera sends R5G3 first and G3B5 second; split them into fields.
    function automatic logic [PIX_W-1:0] pack_rgb565(input logic [7:0] hi,
                                                     input logic [7:0] lo);
        logic [PIX_W-1:0] px;
        px                = '0;
        px[R_MSB:R_LSB]   = hi[7:3];
        px[G_MSB:G_LSB]   = {hi[2:0], lo[7:5]};
        px[B_MSB:B_LSB]   = lo[4:0];
        return px;
    endfunction

endpackage

// File: rtl/cam_capture_writer_if.sv
// Write side of the asynchronous pixel FIFO feeding the display block.
interface cam_capture_writer_if;
    import cam_capture_writer_pkg::*;

    logic             wr_en;
    logic [PIX_W-1:0] dout;
    logic             full_fifo;

    modport master (output wr_en, output dout, input  full_fifo);
    modport slave  (input  wr_en, input  dout, output full_fifo);

endinterface

// File: rtl/cam_capture_writer_sync_edge.sv
// N-stage synchronizer for one asynchronous camera control line, with
// single-cycle rise/fall pulses derived from the synchronized copy.
module cam_capture_writer_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    // Shift the input through the chain and remember the previous synced level
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
        prev_d = sync_q[STAGES-1];
    end

    // Synchronizer and edge-history registers, cleared on reset
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values;
        // blocking here would collapse the chain into a single stage.
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_out = sync_q[STAGES-1];
    assign rise     = sync_out & ~prev_q;
    assign fall     = ~sync_out & prev_q;

endmodule

// File: rtl/cam_capture_writer.sv
// Camera DVP capture: aligns to frame start, pairs bytes into RGB565 pixels,
// crops to the active window and pushes pixels into the display FIFO.
module cam_capture_writer
    import cam_capture_writer_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cam_pclk,
    input  logic                 cam_vsync,
    input  logic                 cam_href,
    input  logic [7:0]           cam_data,
    cam_capture_writer_if.master fifo,
    output logic                 frame_start,
    output logic                 frame_done,
    output logic                 overflow,
    output logic                 frame_err,
    output logic [X_W-1:0]       pix_x,
    output logic [Y_W-1:0]       pix_y
);

    localparam logic [X_W-1:0] X_LIMIT = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0] Y_LAST  = Y_W'(V_ACTIVE - 1);

    // Synchronized camera controls
    logic pclk_s, pclk_rise, pclk_fall;
    logic vsync_s, vsync_rise, vsync_fall;
    logic href_s, href_rise, href_fall;

    cam_capture_writer_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_pclk (
        .clk(clk), .rst(rst), .async_in(cam_pclk),
        .sync_out(pclk_s), .rise(pclk_rise), .fall(pclk_fall)
    );

    cam_capture_writer_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_vsync (
        .clk(clk), .rst(rst), .async_in(cam_vsync),
        .sync_out(vsync_s), .rise(vsync_rise), .fall(vsync_fall)
    );

    cam_capture_writer_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_href (
        .clk(clk), .rst(rst), .async_in(cam_href),
        .sync_out(href_s), .rise(href_rise), .fall(href_fall)
    );

    // Only the pclk rising edge matters; the level and falling edge are spare.
    logic unused_pclk;
    assign unused_pclk = &{1'b0, pclk_s, pclk_fall};

    // Data bus uses the same depth as the controls so bytes stay aligned with pclk
    logic [SYNC_STAGES-1:0][7:0] data_sync_q, data_sync_d;
    logic [7:0]                  data_s;

    // Shift the camera byte through its synchronizer chain
    always_comb begin
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], cam_data};
    end

    // Data synchronizer registers
    always_ff @(posedge clk) begin
        if (rst) data_sync_q <= '0;
        else     data_sync_q <= data_sync_d;
    end

    assign data_s = data_sync_q[SYNC_STAGES-1];

    // Capture state
    cam_state_e       state_q, state_d;
    byte_phase_e      phase_q, phase_d;
    logic [7:0]       hi_q, hi_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic             wr_en_q, wr_en_d;
    logic [PIX_W-1:0] dout_q, dout_d;
    logic             fs_q, fs_d;
    logic             fd_q, fd_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    // Next-state, byte pairing, cropping and error tracking
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        state_d = state_q;
        phase_d = phase_q;
        hi_d    = hi_q;
        x_d     = x_q;
        y_d     = y_q;
        wr_en_d = 1'b0;
        dout_d  = dout_q;
        fs_d    = 1'b0;
        fd_d    = 1'b0;
        ovf_d   = ovf_q;
        err_d   = err_q;

        unique case (state_q)
            WAIT_VS_HIGH: begin
                if (vsync_s) state_d = WAIT_VS_LOW;
            end

            WAIT_VS_LOW: begin
                if (vsync_fall) begin
                    state_d = FRAME;
                    fs_d    = 1'b1;
                    x_d     = '0;
                    y_d     = '0;
                    phase_d = PH_HI;
                end
            end

            FRAME: begin
                if (vsync_rise) begin
                    err_d   = 1'b1;
                    phase_d = PH_HI;
                    state_d = WAIT_VS_LOW;
                end else if (href_rise) begin
                    // A byte arriving with the href edge is the line's first byte
                    state_d = LINE;
                    x_d     = '0;
                    phase_d = PH_HI;
                    if (pclk_rise) begin
                        hi_d    = data_s;
                        phase_d = PH_LO;
                    end
                end
            end

            LINE: begin
                if (vsync_rise) begin
                    err_d   = 1'b1;
                    phase_d = PH_HI;
                    state_d = WAIT_VS_LOW;
                end else if (href_fall) begin
                    // Half pixel or short line at line end are framing errors
                    if (phase_q == PH_LO || x_q < X_LIMIT) err_d = 1'b1;
                    phase_d = PH_HI;
                    x_d     = '0;
                    if (y_q == Y_LAST) begin
                        fd_d    = 1'b1;
                        y_d     = '0;
                        state_d = WAIT_VS_HIGH;
                    end else begin
                        y_d     = y_q + Y_W'(1);
                        state_d = FRAME;
                    end
                end else if (pclk_rise && href_s) begin
                    if (phase_q == PH_HI) begin
                        hi_d    = data_s;
                        phase_d = PH_LO;
                    end else begin
                        phase_d = PH_HI;
                        // Pixels beyond the window are dropped; x stays saturated
                        if (x_q < X_LIMIT) begin
                            if (fifo.full_fifo) begin
                                ovf_d = 1'b1;
                            end else begin
                                wr_en_d = 1'b1;
                                dout_d  = pack_rgb565(hi_q, data_s);
                            end
                            x_d = x_q + X_W'(1);
                        end
                    end
                end
            end

            default: state_d = WAIT_VS_HIGH;
        endcase
    end

    // Capture state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_VS_HIGH;
            phase_q <= PH_HI;
            hi_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            wr_en_q <= 1'b0;
            dout_q  <= '0;
            fs_q    <= 1'b0;
            fd_q    <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            hi_q    <= hi_d;
            x_q     <= x_d;
            y_q     <= y_d;
            wr_en_q <= wr_en_d;
            dout_q  <= dout_d;
            fs_q    <= fs_d;
            fd_q    <= fd_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign fifo.wr_en  = wr_en_q;
    assign fifo.dout   = dout_q;
    assign frame_start = fs_q;
    assign frame_done  = fd_q;
    assign overflow    = ovf_q;
    assign frame_err   = err_q;
    assign pix_x       = x_q;
    assign pix_y       = y_q;

endmodule

// File: tb/tb_cam_capture_writer.sv
// Directed bench for cam_capture_writer using a reduced 24x6 window.
module tb_cam_capture_writer;

    localparam int H = 24;
    localparam int V = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cam_pclk = 1'b0;
    logic       cam_vsync = 1'b0;
    logic       cam_href = 1'b0;
    logic [7:0] cam_data = 8'h00;
    logic       frame_start, frame_done, overflow, frame_err;
    logic [9:0] pix_x;
    logic [8:0] pix_y;

    cam_capture_writer_if fifo_if ();

    cam_capture_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .fifo(fifo_if.master),
        .frame_start(frame_start), .frame_done(frame_done),
        .overflow(overflow), .frame_err(frame_err),
        .pix_x(pix_x), .pix_y(pix_y)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] wq[$];
    int          fs_cnt = 0;
    int          fd_cnt = 0;
    bit          pat_f81f = 1'b0;

    // Record every FIFO write and frame pulse, sampled on the falling edge
    always @(negedge clk) begin
        if (fifo_if.wr_en) wq.push_back(fifo_if.dout);
        if (frame_start)   fs_cnt++;
        if (frame_done)    fd_cnt++;
    end

    function automatic logic [7:0] px_hi(input int y);
        return pat_f81f ? 8'hF8 : (8'hA0 + y[7:0]);
    endfunction

    function automatic logic [7:0] px_lo(input int x);
        return pat_f81f ? 8'h1F : x[7:0];
    endfunction

    // All stimulus edges fall on clk negedges (multiples of 10)
    task automatic send_byte(input logic [7:0] b, input logic f);
        cam_data = b;
        cam_pclk = 1'b0;
        #20;
        cam_pclk = 1'b1;
        fifo_if.full_fifo = f;
        #20;
    endtask

    task automatic send_line(input int y, input int npix, input bit extra,
                             input int full_lo, input int full_hi);
        logic f;
        cam_href = 1'b1;
        for (int x = 0; x < npix; x++) begin
            f = (x >= full_lo && x <= full_hi);
            send_byte(px_hi(y), f);
            send_byte(px_lo(x), f);
        end
        if (extra) send_byte(px_hi(y), 1'b0);
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        #80;
    endtask

    task automatic vsync_pulse();
        cam_vsync = 1'b1;
        #60;
        cam_vsync = 1'b0;
        #60;
    endtask

    task automatic send_frame();
        for (int y = 0; y < V; y++) send_line(y, H, 1'b0, 1000, 1000);
        #100;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cam_pclk = 1'b0;
        cam_vsync = 1'b0;
        cam_href = 1'b0;
        cam_data = 8'h00;
        fifo_if.full_fifo = 1'b0;
        #30;
        rst = 1'b0;
        #20;
    endtask

    task automatic test_reset();
        fifo_if.full_fifo = 1'b0;
        #30;
        checks++;
        if ({fifo_if.wr_en, fifo_if.dout, frame_start, frame_done, overflow, frame_err} !== 21'h0) begin
            errors++;
            $display("FAIL reset_outputs got wr=%b dout=%h fs=%b fd=%b ovf=%b err=%b want all 0",
                     fifo_if.wr_en, fifo_if.dout, frame_start, frame_done, overflow, frame_err);
        end
        checks++;
        if ({pix_x, pix_y} !== 19'h0) begin
            errors++;
            $display("FAIL reset_pix got x=%0d y=%0d want 0 0", pix_x, pix_y);
        end
        rst = 1'b0;
        #40;
        checks++;
        if ({fifo_if.wr_en, frame_start, overflow, frame_err} !== 4'h0) begin
            errors++;
            $display("FAIL post_reset_idle got wr=%b fs=%b ovf=%b err=%b want 0",
                     fifo_if.wr_en, frame_start, overflow, frame_err);
        end
    endtask

    task automatic test_full_frame();
        int base, fs0, fd0, nbad;
        do_reset();
        pat_f81f = 1'b1;
        base = wq.size(); fs0 = fs_cnt; fd0 = fd_cnt;
        vsync_pulse();
        send_frame();
        nbad = 0;
        for (int i = base; i < wq.size(); i++) if (wq[i] !== 16'hF81F) nbad++;
        checks++;
        if (wq.size() - base !== H * V) begin
            errors++;
            $display("FAIL full_write_count got %0d want %0d", wq.size() - base, H * V);
        end
        checks++;
        if (nbad !== 0) begin
            errors++;
            $display("FAIL full_dout got %0d pixels not F81F want 0", nbad);
        end
        checks++;
        if (fs_cnt - fs0 !== 1) begin
            errors++;
            $display("FAIL full_frame_start got %0d want 1", fs_cnt - fs0);
        end
        checks++;
        if (fd_cnt - fd0 !== 1) begin
            errors++;
            $display("FAIL full_frame_done got %0d want 1", fd_cnt - fd0);
        end
        checks++;
        if ({overflow, frame_err} !== 2'b00) begin
            errors++;
            $display("FAIL full_flags got ovf=%b err=%b want 0 0", overflow, frame_err);
        end
        checks++;
        if ({pix_x, pix_y} !== 19'h0) begin
            errors++;
            $display("FAIL full_pix_end got x=%0d y=%0d want 0 0", pix_x, pix_y);
        end
        pat_f81f = 1'b0;
    endtask

    task automatic test_mid_frame_start();
        int base, fd0;
        do_reset();
        base = wq.size(); fd0 = fd_cnt;
        send_line(2, H, 1'b0, 1000, 1000);
        send_line(3, H, 1'b0, 1000, 1000);
        checks++;
        if (wq.size() - base !== 0) begin
            errors++;
            $display("FAIL mid_no_write got %0d writes want 0", wq.size() - base);
        end
        vsync_pulse();
        send_frame();
        checks++;
        if (wq.size() - base !== H * V) begin
            errors++;
            $display("FAIL mid_write_count got %0d want %0d", wq.size() - base, H * V);
        end else begin
            checks++;
            if (wq[base] !== 16'hA000) begin
                errors++;
                $display("FAIL mid_first_pixel got %h want A000", wq[base]);
            end
            checks++;
            if (wq[base + H * V - 1] !== 16'hA517) begin
                errors++;
                $display("FAIL mid_last_pixel got %h want A517", wq[base + H * V - 1]);
            end
        end
        checks++;
        if (fd_cnt - fd0 !== 1) begin
            errors++;
            $display("FAIL mid_frame_done got %0d want 1", fd_cnt - fd0);
        end
    endtask

    task automatic test_overflow();
        int base;
        do_reset();
        base = wq.size();
        vsync_pulse();
        for (int y = 0; y < V; y++) send_line(y, H, 1'b0, (y == 3) ? 10 : 1000, 19);
        #100;
        checks++;
        if (wq.size() - base !== H * V - 10) begin
            errors++;
            $display("FAIL ovf_write_count got %0d want %0d", wq.size() - base, H * V - 10);
        end else begin
            checks++;
            if (wq[base + 3 * H + 9] !== 16'hA309) begin
                errors++;
                $display("FAIL ovf_before_gap got %h want A309", wq[base + 3 * H + 9]);
            end
            checks++;
            if (wq[base + 3 * H + 10] !== 16'hA314) begin
                errors++;
                $display("FAIL ovf_after_gap got %h want A314", wq[base + 3 * H + 10]);
            end
        end
        checks++;
        if ({overflow, frame_err} !== 2'b10) begin
            errors++;
            $display("FAIL ovf_flags got ovf=%b err=%b want 1 0", overflow, frame_err);
        end
    endtask

    task automatic test_line_length();
        int npix_t[4]  = '{H + 2, H, H - 1, H - 1};
        bit extra_t[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int exp_w_t[4] = '{H, H, H - 1, H - 1};
        bit exp_e_t[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        int base;
        logic [15:0] exp_last;
        for (int k = 0; k < 4; k++) begin
            do_reset();
            base = wq.size();
            vsync_pulse();
            send_line(0, npix_t[k], extra_t[k], 1000, 1000);
            #100;
            exp_last = {8'hA0, 8'(exp_w_t[k] - 1)};
            checks++;
            if (wq.size() - base !== exp_w_t[k]) begin
                errors++;
                $display("FAIL len%0d_writes got %0d want %0d", k, wq.size() - base, exp_w_t[k]);
            end else begin
                checks++;
                if (wq[wq.size() - 1] !== exp_last) begin
                    errors++;
                    $display("FAIL len%0d_last got %h want %h", k, wq[wq.size() - 1], exp_last);
                end
            end
            checks++;
            if (frame_err !== exp_e_t[k]) begin
                errors++;
                $display("FAIL len%0d_frame_err got %b want %b", k, frame_err, exp_e_t[k]);
            end
            checks++;
            if (pix_y !== 9'd1) begin
                errors++;
                $display("FAIL len%0d_pix_y got %0d want 1", k, pix_y);
            end
        end
    endtask

    task automatic test_vsync_abort();
        int fs0, fd0, base;
        do_reset();
        fs0 = fs_cnt; fd0 = fd_cnt;
        vsync_pulse();
        for (int y = 0; y < 3; y++) send_line(y, H, 1'b0, 1000, 1000);
        vsync_pulse();
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL abort_frame_err got %b want 1", frame_err);
        end
        checks++;
        if (fd_cnt - fd0 !== 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d want 0", fd_cnt - fd0);
        end
        checks++;
        if (fs_cnt - fs0 !== 2) begin
            errors++;
            $display("FAIL abort_restart got %0d frame_start want 2", fs_cnt - fs0);
        end
        base = wq.size();
        send_frame();
        checks++;
        if (wq.size() - base !== H * V) begin
            errors++;
            $display("FAIL abort_next_count got %0d want %0d", wq.size() - base, H * V);
        end else begin
            checks++;
            if (wq[base] !== 16'hA000) begin
                errors++;
                $display("FAIL abort_next_first got %h want A000", wq[base]);
            end
        end
        checks++;
        if (fd_cnt - fd0 !== 1) begin
            errors++;
            $display("FAIL abort_next_done got %0d want 1", fd_cnt - fd0);
        end
    endtask

    task automatic test_reset_split();
        int base;
        do_reset();
        base = wq.size();
        vsync_pulse();
        cam_href = 1'b1;
        for (int x = 0; x < 2; x++) begin
            send_byte(px_hi(0), 1'b0);
            send_byte(px_lo(x), 1'b0);
        end
        send_byte(px_hi(0), 1'b0);
        #10;
        checks++;
        if (wq.size() - base !== 2 || pix_x !== 10'd2) begin
            errors++;
            $display("FAIL split_pre got writes=%0d x=%0d want 2 2", wq.size() - base, pix_x);
        end
        base = wq.size();
        rst = 1'b1;
        #10;
        checks++;
        if ({fifo_if.wr_en, fifo_if.dout, frame_start, frame_done, overflow, frame_err,
             pix_x, pix_y} !== 40'h0) begin
            errors++;
            $display("FAIL split_reset_out got wr=%b dout=%h x=%0d y=%0d want all 0",
                     fifo_if.wr_en, fifo_if.dout, pix_x, pix_y);
        end
        #10;
        rst = 1'b0;
        send_byte(px_lo(2), 1'b0);
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        #100;
        checks++;
        if (wq.size() - base !== 0) begin
            errors++;
            $display("FAIL split_no_write got %0d writes want 0", wq.size() - base);
        end
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL split_frame_err got %b want 0", frame_err);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_mid_frame_start();
        test_overflow();
        test_line_length();
        test_vsync_abort();
        test_reset_split();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
